// File: rtl/display_pkg.sv
// Shared constants for the BCD display scanner: parameter limits and
// active-low seven-segment patterns (bit0=a ... bit6=g).
package display_pkg;

    localparam int unsigned NUM_DIGITS_MIN = 1;
    localparam int unsigned NUM_DIGITS_MAX = 8;
    localparam int unsigned PRESCALE_MIN   = 2;
    localparam int unsigned PRESCALE_MAX   = 65535;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low seven-segment decoder; codes 10-15 show a dash.
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_n_c
);

    // Pattern lookup; out-of-range codes map to the g-only dash.
    always_comb begin
        seg_n_c = SEG_DASH;
        case (bcd)
            4'd0:    seg_n_c = SEG_0;
            4'd1:    seg_n_c = SEG_1;
            4'd2:    seg_n_c = SEG_2;
            4'd3:    seg_n_c = SEG_3;
            4'd4:    seg_n_c = SEG_4;
            4'd5:    seg_n_c = SEG_5;
            4'd6:    seg_n_c = SEG_6;
            4'd7:    seg_n_c = SEG_7;
            4'd8:    seg_n_c = SEG_8;
            4'd9:    seg_n_c = SEG_9;
            default: seg_n_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed seven-segment scanner with tear-free frame-boundary updates,
// a blank slot at the start of every digit, and a dash for invalid codes.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module bcd_display_scanner
    import display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned PRESCALE   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    output logic [6:0]              seg_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done
);

    localparam int unsigned DW    = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(PRESCALE);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DW-1:0]         pending_q, pending_d;
    logic                  pending_valid_q, pending_valid_d;
    logic [DW-1:0]         display_q, display_d;
    logic [6:0]            seg_n_q, seg_n_d;
    logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
    logic                  frame_done_q, frame_done_d;

    logic                  boundary_c;
    logic                  display_upd_c;
    logic [3:0]            digit_sel_c;
    logic [6:0]            dec_seg_c;

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] blank_q, blank_d;
    logic                  blank_sel_c;

    // Digit i>=1 is blanked when it and every higher digit are zero.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [DW-1:0] d);
        logic [NUM_DIGITS-1:0] m;
        logic                  zero_above;
        m          = '0;
        zero_above = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
            zero_above = zero_above & (d[4*i +: 4] == 4'd0);
            m[i]       = zero_above;
        end
        return m;
    endfunction
`endif

    // Slot counter and digit index advance.
    always_comb begin
        cnt_d      = cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        boundary_c = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Snapshot handling; a load coinciding with the boundary bypasses pending.
    always_comb begin
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        display_d       = display_q;
        display_upd_c   = 1'b0;
        if (load) begin
            pending_d       = digits_in;
            pending_valid_d = 1'b1;
        end
        if (boundary_c) begin
            if (load) begin
                display_d       = digits_in;
                display_upd_c   = 1'b1;
                pending_valid_d = 1'b0;
            end else if (pending_valid_q) begin
                display_d       = pending_q;
                display_upd_c   = 1'b1;
                pending_valid_d = 1'b0;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Blank mask follows the display register.
    always_comb begin
        blank_d = display_upd_c ? lz_mask(display_d) : blank_q;
    end
`endif

    // Current digit select.
    always_comb begin
        digit_sel_c = 4'd0;
`ifdef LEADING_ZERO_BLANK_EN
        blank_sel_c = 1'b0;
`endif
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                digit_sel_c = display_q[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
                blank_sel_c = blank_q[i];
`endif
            end
        end
    end

    seg7_decoder u_seg7_decoder (
        .bcd     (digit_sel_c),
        .seg_n_c (dec_seg_c)
    );

    // Output stage: blank slot at cnt==0, otherwise drive the selected digit.
    always_comb begin
        seg_n_d      = SEG_BLANK;
        an_n_d       = '1;
        frame_done_d = boundary_c;
        if (cnt_q != '0) begin
`ifdef LEADING_ZERO_BLANK_EN
            seg_n_d = blank_sel_c ? SEG_BLANK : dec_seg_c;
`else
            seg_n_d = dec_seg_c;
`endif
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                if (idx_q == IDX_W'(i)) an_n_d[i] = 1'b0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q           <= '0;
            idx_q           <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            display_q       <= '0;
            seg_n_q         <= SEG_BLANK;
            an_n_q          <= '1;
            frame_done_q    <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            blank_q         <= lz_mask(DW'(0));
`endif
        end else begin
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            display_q       <= display_d;
            seg_n_q         <= seg_n_d;
            an_n_q          <= an_n_d;
            frame_done_q    <= frame_done_d;
`ifdef LEADING_ZERO_BLANK_EN
            blank_q         <= blank_d;
`endif
        end
    end

    assign seg_n      = seg_n_q;
    assign an_n       = an_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/bcd_display_scanner.md
# bcd_display_scanner

Time-multiplexed seven-segment display driver that sits directly downstream of the BCD digit counters. Snapshots a bus of packed 4-bit digits on a strobe, applies them at frame boundaries to avoid tearing, and scans one digit at a time onto a shared active-low segment bus with per-digit active-low enables. Includes an anti-ghosting blank slot and an invalid-code indicator.

## Interface
- NUM_DIGITS, 4: digits scanned; range 1–8.
- PRESCALE, 4: clk cycles per digit slot; range 2–65535.
- clk  in  1  rising-edge clock, single domain.
- rst  in  1  synchronous, active-high reset.
- digits_in  in  4*NUM_DIGITS  packed digits; digit i = bits [4i+3:4i]; digit 0 = rightmost.
- load  in  1  snapshot strobe; captures digits_in this cycle.
- seg_n  out  7  segments, active-low; bit0=a … bit6=g.
- an_n  out  NUM_DIGITS  digit enables, active-low; at most one low.
- frame_done  out  1  one-cycle pulse on the last cycle of each full scan.

## Operation
- State: slot counter cnt (0..PRESCALE-1), digit index idx (0..NUM_DIGITS-1), pending register + pending_valid flag, display register.
- cnt increments every cycle; at PRESCALE-1 it wraps to 0 and idx advances; idx wraps NUM_DIGITS-1 → 0.
- Frame boundary: cnt==PRESCALE-1 and idx==NUM_DIGITS-1. frame_done is high exactly in that cycle.
- load high: pending ← digits_in, pending_valid ← 1. Repeated loads before a boundary overwrite; last one wins.
- At a frame boundary with pending_valid=1: display ← pending, pending_valid ← 0. The new value is shown from the following idx=0 slot.
- load and a frame boundary in the same cycle: the digits_in captured in that cycle are transferred at that boundary. Bypass pending; no frame delay.
- Decode, per digit:
  - 0 → 1000000; 1 → 1111001; 2 → 0100100; 3 → 0110000; 4 → 0011001.
  - 5 → 0010010; 6 → 0000010; 7 → 1111000; 8 → 0000000; 9 → 0010000.
  - 10–15 → dash 0111111 (g only).
- Anti-ghosting: during cnt==0 of every slot, an_n is all ones and seg_n is all ones. During cnt 1..PRESCALE-1, an_n[idx]=0.
- Reset values:
  - cnt=0, idx=0, pending=0, pending_valid=0, display=0.
  - seg_n=7'h7F, an_n all ones, frame_done=0.
- Reset mid-scan discards pending and display. The scan restarts at idx 0, cnt 0 on the first cycle after rst deasserts.

## Timing
- seg_n, an_n and frame_done are registered, one cycle behind cnt/idx/display.
- frame_done rises in the clk edge after the boundary state.
- Full frame = NUM_DIGITS*PRESCALE cycles.
- Latency from load to first display: up to one frame plus one cycle, which is the wait for the next boundary plus the output register.
- With rst released at cycle 0:
  - an_n[0] first goes low in the output at cycle 2 (cnt=1 registered).
  - The first frame_done output pulse is at cycle NUM_DIGITS*PRESCALE.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Digit i (i≥1) is blanked if it and every higher digit in display equal 0.
  - Blanked means seg_n=7'h7F for that slot; an_n still asserts normally.
  - Digit 0 is never blanked. The blank mask is computed from display and registered when display updates.
- Undefined: every digit is always decoded, so leading zeros show as "0". No mask logic is present.

## Structure
- Package display_pkg:
  - SEG_* pattern constants for 0–9, SEG_DASH and SEG_BLANK.
  - Parameter range limits.
- Sub-module seg7_decoder: combinational 4-bit → 7-bit active-low, including the dash mapping. Instantiated once, on the selected digit.

## Test plan
- Reset: hold rst 3 cycles mid-scan with load pulsed. Required: seg_n=7F, an_n all ones, frame_done=0; scan restarts at idx 0; display shows 0000.
- Scan order, NUM_DIGITS=4, PRESCALE=4: load 16'h1234. In the second frame:
  - an_n cycles 1110, 1101, 1011, 0111, each low for 3 of 4 cycles.
  - seg_n = 0011001, 0110000, 0100100, 1111001.
  - frame_done pulses every 16 cycles.
- Invalid code: load 16'h9A05. Required: digit1 shows 1000000, digit2 shows 0111111 (dash), digit3 shows 0010000.
- Tear-free update:
  - Load 16'h1111, then 16'h2222 at idx=2. The current frame stays all "1"; the next frame is all "2".
  - load coincident with the boundary: that value is applied immediately.
- LEADING_ZERO_BLANK_EN, load 16'h0007: digits 3..1 seg_n=7F, digit0=1111000. Load 16'h0000: only digit0 lit, showing 1000000. Without the macro, all four digits show 1000000.
- Ghost guard: at every cnt==0 output cycle, an_n is all ones. Check at PRESCALE=2.
